mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Parametrised shared-memory access unit for the multicycle CPU family.
- Arbitrates NUM_CH requestors onto the single readM/writeM/address/inout-data memory bus the CPU top drives; default NUM_CH=2 covers instruction fetch plus data access.
- Adds what the current single-port memory interface lacks: round-robin arbitration, configurable memory latency, a request/response handshake and an access counter.

Parameters:
- WORD_SIZE, 16, data bus width in bits.
- ADDR_SIZE, 16, address width in bits.
- NUM_CH, 2, number of requestors; legal range 2..8.
- MEM_LATENCY, 1, cycles readM/writeM are held per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_CH  per-channel request.
- req_write  input  NUM_CH  per-channel: 1=write, 0=read.
- req_addr  input  NUM_CH*ADDR_SIZE  flattened; channel i occupies bits [i*ADDR_SIZE +: ADDR_SIZE].
- req_wdata  input  NUM_CH*WORD_SIZE  flattened write data, same packing as req_addr.
- req_ready  output  NUM_CH  one-hot, one-cycle grant pulse.
- rsp_valid  output  NUM_CH  one-hot, one-cycle completion pulse.
- rsp_rdata  output  WORD_SIZE  read data; valid while rsp_valid is high.
- readM  output  1  memory read strobe.
- writeM  output  1  memory write strobe.
- address  output  ADDR_SIZE  memory address.
- data  inout  WORD_SIZE  memory data bus.
- busy  output  1  high whenever state is not IDLE.
- access_count  output  WORD_SIZE  number of completed accesses.

Behaviour:
- Reset (asynchronous, immediate):
  - State=IDLE.
  - readM=writeM=0, address=0, data=Z.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, busy=0, access_count=0.
  - last_grant=NUM_CH-1, so channel 0 wins first.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise, at the clock edge, pick the winner by round-robin: the first set req_valid bit searching last_grant+1, last_grant+2, ... modulo NUM_CH.
  - Latch the winner's channel, write flag, addr and wdata. Set last_grant=winner. Load lat_cnt=MEM_LATENCY-1. Go to ACCESS.
- ACCESS:
  - req_ready[ch]=1 in the first ACCESS cycle only.
  - address=latched addr.
  - readM=~write, writeM=write.
  - data=latched wdata on a write, Z on a read.
  - lat_cnt decrements each cycle.
  - At the edge where lat_cnt==0: on a read, sample data into rsp_rdata; go to DONE.
  - readM/writeM stay high for exactly MEM_LATENCY cycles.
- DONE:
  - rsp_valid[ch]=1 for one cycle. readM=writeM=0, data=Z, address holds.
  - access_count increments by 1, modulo 2^WORD_SIZE.
  - Go to IDLE.
- Timing and throughput:
  - Latency from the request being seen in IDLE to rsp_valid is MEM_LATENCY+1 cycles.
  - Throughput is one access per MEM_LATENCY+2 cycles.
- Handshake rules:
  - A requestor holds req_valid, req_write, req_addr and req_wdata stable until it sees req_ready.
  - Fields are captured at the grant edge; later changes are ignored.
  - A requestor deasserts req_valid in the cycle after req_ready, or leaves it high to queue the next request.
  - Only one access is outstanding at a time.
- On writes, rsp_valid pulses as an acknowledge and rsp_rdata keeps its previous value.
- Requests arriving during ACCESS or DONE wait; they are evaluated only in IDLE.
- Simultaneous requests are served in strict rotation; no channel waits more than NUM_CH-1 grants.
- The arbiter never drives data outside the ACCESS cycles of a write.
- Reset during ACCESS or DONE:
  - The access is abandoned and no rsp_valid is issued.
  - The bus is released in the same cycle as reset asserts.
  - The counter clears.

Test Plan:
- Single read, defaults: ch0 reads 0x0040 while memory returns 0xBEEF -> readM high 1 cycle with address=0x0040; rsp_valid[0] 2 cycles after the request edge with rsp_rdata=0xBEEF; access_count=1.
- Write: ch1 writes 0x1234 to 0x0080 -> writeM high 1 cycle with data=0x1234; data is Z in the IDLE and DONE cycles; rsp_valid[1] pulses; rsp_rdata unchanged.
- Contention, NUM_CH=4: all four req_valid held high from reset -> grant order 0,1,2,3,0,…; each rsp_valid one-hot; access_count=8 after 8 responses.
- Latency, MEM_LATENCY=3: read -> readM held exactly 3 cycles; data sampled only in the last of them; rsp_valid 4 cycles after the request edge.
- Reset mid-access, MEM_LATENCY=3: assert reset during the 2nd ACCESS cycle -> readM/writeM drop and data goes Z immediately; no rsp_valid; access_count=0; after release, ch0 wins first.
- Counter wrap, WORD_SIZE=4: 17 accesses -> access_count reads 0 after the 16th and 1 after the 17th.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one readM/writeM/address/data memory port among NUM_CH requestors.
// Each access holds its strobe for MEM_LATENCY cycles and finishes with a one-cycle response.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE   = 16,
    parameter int unsigned ADDR_SIZE   = 16,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH-1:0]             req_write,
    input  logic [NUM_CH*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_CH*WORD_SIZE-1:0]   req_wdata,
    output logic [NUM_CH-1:0]             req_ready,
    output logic [NUM_CH-1:0]             rsp_valid,
    output logic [WORD_SIZE-1:0]          rsp_rdata,
    output logic                          readM,
    output logic                          writeM,
    output logic [ADDR_SIZE-1:0]          address,
    inout  wire  [WORD_SIZE-1:0]          data,
    output logic                          busy,
    output logic [WORD_SIZE-1:0]          access_count
);

    localparam int unsigned     ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned     LatW  = 4;
    localparam logic [NUM_CH-1:0] ChOne = NUM_CH'(1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e               state_q, state_d;
    logic [ChW-1:0]       ch_q, ch_d;
    logic [ChW-1:0]       last_grant_q, last_grant_d;
    logic                 write_q, write_d;
    logic [ADDR_SIZE-1:0] address_q, address_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic [LatW-1:0]      lat_cnt_q, lat_cnt_d;
    logic [NUM_CH-1:0]    req_ready_q, req_ready_d;
    logic [NUM_CH-1:0]    rsp_valid_q, rsp_valid_d;
    logic [WORD_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [WORD_SIZE-1:0] access_count_q, access_count_d;
    logic                 read_m_q, read_m_d;
    logic                 write_m_q, write_m_d;
    logic                 data_oe_q, data_oe_d;

    logic [ADDR_SIZE-1:0] addr_arr  [NUM_CH];
    logic [WORD_SIZE-1:0] wdata_arr [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[g*ADDR_SIZE +: ADDR_SIZE];
        assign wdata_arr[g] = req_wdata[g*WORD_SIZE +: WORD_SIZE];
    end

    logic           win_found;
    logic [ChW-1:0] win_ch;
    logic [ChW-1:0] cand;

    // First requesting channel after last_grant, wrapping modulo NUM_CH.
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = ChW'((32'(last_grant_q) + k) % NUM_CH);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ch_d           = ch_q;
        last_grant_d   = last_grant_q;
        write_d        = write_q;
        address_d      = address_q;
        wdata_d        = wdata_q;
        lat_cnt_d      = lat_cnt_q;
        req_ready_d    = '0;
        rsp_valid_d    = '0;
        rsp_rdata_d    = rsp_rdata_q;
        access_count_d = access_count_q;
        read_m_d       = read_m_q;
        write_m_d      = write_m_q;
        data_oe_d      = data_oe_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    ch_d         = win_ch;
                    last_grant_d = win_ch;
                    write_d      = req_write[win_ch];
                    address_d    = addr_arr[win_ch];
                    wdata_d      = wdata_arr[win_ch];
                    lat_cnt_d    = LatW'(MEM_LATENCY - 1);
                    req_ready_d  = ChOne << win_ch;
                    read_m_d     = ~req_write[win_ch];
                    write_m_d    = req_write[win_ch];
                    data_oe_d    = req_write[win_ch];
                    state_d      = StAccess;
                end
            end
            StAccess: begin
                if (lat_cnt_q == '0) begin
                    // Last strobe cycle: memory read data is valid on the bus now.
                    if (!write_q) begin
                        rsp_rdata_d = data;
                    end
                    read_m_d       = 1'b0;
                    write_m_d      = 1'b0;
                    data_oe_d      = 1'b0;
                    rsp_valid_d    = ChOne << ch_q;
                    access_count_d = access_count_q + WORD_SIZE'(1);
                    state_d        = StDone;
                end else begin
                    lat_cnt_d = lat_cnt_q - LatW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            ch_q           <= '0;
            last_grant_q   <= ChW'(NUM_CH - 1);
            write_q        <= 1'b0;
            address_q      <= '0;
            wdata_q        <= '0;
            lat_cnt_q      <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            access_count_q <= '0;
            read_m_q       <= 1'b0;
            write_m_q      <= 1'b0;
            data_oe_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            last_grant_q   <= last_grant_d;
            write_q        <= write_d;
            address_q      <= address_d;
            wdata_q        <= wdata_d;
            lat_cnt_q      <= lat_cnt_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            access_count_q <= access_count_d;
            read_m_q       <= read_m_d;
            write_m_q      <= write_m_d;
            data_oe_q      <= data_oe_d;
        end
    end

    assign data         = data_oe_q ? wdata_q : {WORD_SIZE{1'bz}};
    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign readM        = read_m_q;
    assign writeM       = write_m_q;
    assign address      = address_q;
    assign busy         = (state_q != StIdle);
    assign access_count = access_count_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four channels, three-cycle memory, 8-bit words so the counter wraps.
// A transaction-level model predicts every output from grant edge offsets and a shadow memory.
module tb_mem_port_arbiter;

    localparam int W = 8;
    localparam int A = 16;
    localparam int N = 4;
    localparam int L = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid, req_write;
    logic [N*A-1:0]   req_addr;
    logic [N*W-1:0]   req_wdata;
    logic [N-1:0]     req_ready, rsp_valid;
    logic [W-1:0]     rsp_rdata;
    logic             readM, writeM;
    logic [A-1:0]     address;
    wire  [W-1:0]     data;
    logic             busy;
    logic [W-1:0]     access_count;

    mem_port_arbiter #(
        .WORD_SIZE   (W),
        .ADDR_SIZE   (A),
        .NUM_CH      (N),
        .MEM_LATENCY (L)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .readM        (readM),
        .writeM       (writeM),
        .address      (address),
        .data         (data),
        .busy         (busy),
        .access_count (access_count)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] init_val(int i);
        return W'(i * 37 + 5);
    endfunction

    // Memory environment: returns the true word only in the final strobe cycle.
    logic [W-1:0] mem_env [256];
    int           rd_cnt = 0;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem_env[i] <= init_val(i);
            rd_cnt <= 0;
        end else begin
            if (writeM) mem_env[address[7:0]] <= data;
            rd_cnt <= readM ? rd_cnt + 1 : 0;
        end
    end

    assign data = readM ? ((rd_cnt == L - 1) ? mem_env[address[7:0]] : ~mem_env[address[7:0]])
                        : {W{1'bz}};

    // Reference model state
    int           checks, errors, cyc, mode;
    bit           m_act;
    int           m_g, m_ch, m_last, m_free, m_count;
    logic         m_w;
    logic [A-1:0] m_addr;
    logic [W-1:0] m_wdata, m_rdata;
    logic [W-1:0] ref_mem [256];
    int           dut_grants[$];

    typedef struct {
        logic [N-1:0] valid;
        logic [N-1:0] write;
        logic [N-1:0] exp_ready;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want %h", name, cyc, act, exp);
        end
    endtask

    // An undriven bus reads as z, or as 0 on a two-state simulator.
    task automatic chk_released(string name);
        checks++;
        if (!(data === {W{1'bz}} || data === {W{1'b0}})) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h want z", name, cyc, data);
        end
    endtask

    function automatic int ch_of(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 99;
    endfunction

    task automatic model_reset();
        m_act   = 1'b0;
        m_last  = N - 1;
        m_free  = 0;
        m_addr  = '0;
        m_rdata = '0;
        m_count = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic new_req(int ch);
        req_valid[ch]         = 1'b1;
        req_write[ch]         = 1'($urandom_range(0, 1));
        req_addr[ch*A +: A]   = A'($urandom);
        req_wdata[ch*W +: W]  = W'($urandom_range(1, 255));
    endtask

    task automatic check_cycle();
        int           off;
        logic [N-1:0] e_ready, e_rsp;
        logic         e_rd, e_wr, e_busy;
        off     = cyc - m_g;
        e_ready = '0;
        e_rsp   = '0;
        e_rd    = 1'b0;
        e_wr    = 1'b0;
        e_busy  = 1'b0;
        if (m_act) begin
            if (off == 0) e_ready = N'(1) << m_ch;
            e_rd   = !m_w && off < L;
            e_wr   = m_w && off < L;
            e_busy = off <= L;
            if (off == L) begin
                e_rsp   = N'(1) << m_ch;
                m_count = (m_count + 1) % 256;
                if (m_w) ref_mem[m_addr[7:0]] = m_wdata;
                else     m_rdata = ref_mem[m_addr[7:0]];
            end
        end
        chk("req_ready", req_ready, e_ready);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("readM", readM, e_rd);
        chk("writeM", writeM, e_wr);
        chk("busy", busy, e_busy);
        chk("address", address, m_addr);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("access_count", access_count, m_count);
        if (e_wr) chk("data_wr", data, m_wdata);
        else if (!e_rd) chk_released("data_idle");
        if (req_ready != '0) dut_grants.push_back(ch_of(req_ready));

        if (e_ready != '0) begin
            if (mode == 1) new_req(m_ch);
            else if (mode == 2) begin
                if ($urandom_range(0, 1) == 1) new_req(m_ch);
                else req_valid[m_ch] = 1'b0;
            end
        end
        if (mode == 2) begin
            for (int c = 0; c < N; c++)
                if (!req_valid[c] && $urandom_range(0, 3) == 0) new_req(c);
        end
    endtask

    task automatic step();
        int win;
        cyc++;
        if (!reset && cyc >= m_free && req_valid != '0) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && req_valid[(m_last + k) % N]) win = (m_last + k) % N;
            end
            m_act   = 1'b1;
            m_g     = cyc;
            m_ch    = win;
            m_w     = req_write[win];
            m_addr  = req_addr[win*A +: A];
            m_wdata = req_wdata[win*W +: W];
            m_last  = win;
            m_free  = cyc + L + 2;
        end
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic run_until_free();
        while (cyc + 1 < m_free) step();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        mode      = 0;
        m_g       = 0;
        m_ch      = 0;
        m_w       = 1'b0;
        m_wdata   = '0;
        reset     = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        model_reset();

        tbl[0] = '{valid: 4'b1111, write: 4'b0000, exp_ready: 4'b0001};
        tbl[1] = '{valid: 4'b1111, write: 4'b1111, exp_ready: 4'b0010};
        tbl[2] = '{valid: 4'b0101, write: 4'b0100, exp_ready: 4'b0100};
        tbl[3] = '{valid: 4'b0101, write: 4'b0000, exp_ready: 4'b0001};
        tbl[4] = '{valid: 4'b1000, write: 4'b1000, exp_ready: 4'b1000};
        tbl[5] = '{valid: 4'b0110, write: 4'b0000, exp_ready: 4'b0010};
        tbl[6] = '{valid: 4'b0011, write: 4'b0001, exp_ready: 4'b0001};
        tbl[7] = '{valid: 4'b0010, write: 4'b0000, exp_ready: 4'b0010};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_readM", readM, 1'b0);
        chk("rst_writeM", writeM, 1'b0);
        chk("rst_address", address, '0);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", access_count, '0);
        chk_released("rst_data");

        // Contention: every channel requests continuously from reset release.
        mode = 1;
        for (int c = 0; c < N; c++) new_req(c);
        reset = 1'b0;
        dut_grants.delete();
        repeat (8 * (L + 2)) step();
        for (int i = 0; i < 8; i++)
            chk("rr_order", (i < dut_grants.size()) ? dut_grants[i] : 99, i % N);
        chk("count_after_8", access_count, 8);
        req_valid = '0;
        mode      = 0;
        run_until_free();

        // Table: fixed requester patterns starting from last_grant = 3.
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < N; c++) begin
                req_addr[c*A +: A]  = A'(16'h0040 * (c + 1));
                req_wdata[c*W +: W] = W'(8'h12 + 8'h11 * c);
            end
            req_valid = tbl[i].valid;
            req_write = tbl[i].write;
            step();
            chk("tbl_ready", req_ready, tbl[i].exp_ready);
            req_valid = '0;
            run_until_free();
        end

        // Random traffic long enough to wrap the 8-bit access counter.
        mode = 2;
        repeat (2500) step();
        mode      = 0;
        req_valid = '0;
        run_until_free();
        step();

        // Reset in the second strobe cycle of a write.
        new_req(2);
        req_write[2]        = 1'b1;
        req_wdata[2*W +: W] = 8'hA5;
        step();
        req_valid = '0;
        step();
        reset = 1'b1;
        #1;
        chk("midrst_writeM", writeM, 1'b0);
        chk("midrst_readM", readM, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, '0);
        chk("midrst_count", access_count, '0);
        chk_released("midrst_data");
        model_reset();
        repeat (2) step();
        req_valid = '1;
        req_write = '0;
        reset     = 1'b0;
        step();
        chk("post_rst_grant", req_ready, 4'b0001);
        req_valid = '0;
        run_until_free();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
